// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Brief    : Access-size encodings and FSM state type shared by the memory stage
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Brief    : Store lane steering / misalign detect and load byte-select / extend
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic        o_misaligned,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_lane_data,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shift;

    // Size 3 falls into the word branch.
    always_comb begin
        o_misaligned   = 1'b0;
        o_st_be        = 4'b1111;
        o_st_lane_data = i_st_wdata;
        case (i_st_size)
            SZ_B: begin
                o_st_be        = 4'b0001 << i_st_addr_lo;
                o_st_lane_data = {4{i_st_wdata[7:0]}};
            end
            SZ_H: begin
                o_misaligned   = i_st_addr_lo[0];
                o_st_be        = 4'b0011 << i_st_addr_lo;
                o_st_lane_data = {2{i_st_wdata[15:0]}};
            end
            default: o_misaligned = |i_st_addr_lo;
        endcase
    end

    always_comb begin
        w_ld_shift = i_ld_rdata >> {i_ld_addr_lo, 3'b000};
        case (i_ld_size)
            SZ_B:    o_ld_data = {{24{~i_ld_unsigned & w_ld_shift[7]}}, w_ld_shift[7:0]};
            SZ_H:    o_ld_data = {{16{~i_ld_unsigned & w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: o_ld_data = w_ld_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory stage - issues data-memory requests and writeback
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_load_en,
    input  logic            in_store_en,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_res,
    input  logic [4:0]      in_rd,
    input  logic            in_write_reg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign
);

    state_t          r_state;
    state_t          w_state_nxt;

    logic            w_accept;
    logic            w_is_mem;
    logic            w_misaligned;
    logic            w_go_mem;
    logic            w_fast;
    logic            w_acc_done;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_lane_data;
    logic [XLEN-1:0] w_ld_data;

    logic            r_we;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [1:0]      r_ld_size;
    logic [1:0]      r_ld_lo;
    logic            r_ld_uns;
    logic            r_wb_fast;
    logic            r_wb_en;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_misalign;

    mem_align u_align (
        .i_st_size      (in_size),
        .i_st_addr_lo   (in_addr[1:0]),
        .i_st_wdata     (in_wdata),
        .o_misaligned   (w_misaligned),
        .o_st_be        (w_be),
        .o_st_lane_data (w_lane_data),
        .i_ld_size      (r_ld_size),
        .i_ld_addr_lo   (r_ld_lo),
        .i_ld_unsigned  (r_ld_uns),
        .i_ld_rdata     (dmem_rdata),
        .o_ld_data      (w_ld_data)
    );

    // ALU ops and misaligned accesses complete in IDLE without touching memory.
    assign w_accept   = in_valid & in_ready;
    assign w_is_mem   = in_load_en | in_store_en;
    assign w_go_mem   = w_accept & w_is_mem & ~w_misaligned;
    assign w_fast     = w_accept & ~w_go_mem;
    assign w_acc_done = (r_state == ST_ACCESS) & dmem_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_go_mem)   w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (dmem_ready) w_state_nxt = ST_RESP;
            ST_RESP:                   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_IDLE);
        dmem_req = (r_state == ST_ACCESS);
        wb_valid = r_wb_fast | (r_state == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_be       <= 4'b0000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ld_size  <= SZ_W;
            r_ld_lo    <= 2'b00;
            r_ld_uns   <= 1'b0;
            r_wb_fast  <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_wb_fast  <= w_fast;
            r_misalign <= w_accept & w_is_mem & w_misaligned;
            if (w_accept) begin
                r_wb_rd   <= in_rd;
                r_wb_data <= in_res;
                r_wb_en   <= in_write_reg & (in_rd != 5'd0) & ~in_store_en
                             & ~(w_is_mem & w_misaligned);
            end
            if (w_go_mem) begin
                r_we      <= in_store_en;
                r_be      <= w_be;
                r_addr    <= {in_addr[XLEN-1:2], 2'b00};
                r_wdata   <= w_lane_data;
                r_ld_size <= in_size;
                r_ld_lo   <= in_addr[1:0];
                r_ld_uns  <= in_unsigned;
            end
            // Read data is only valid in the dmem_ready cycle, so capture it here.
            if (w_acc_done && !r_we) r_wb_data <= w_ld_data;
        end
    end

    assign dmem_we    = r_we;
    assign dmem_be    = r_be;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign wb_en      = r_wb_en;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign misalign   = r_misalign;

endmodule
`default_nettype wire
